// File: rtl/gate3_response_checker.sv
// Response analyzer for a 3-input gate under test: samples zn a programmable
// settle time after each applied vector, checks it against a truth table and tracks coverage/errors.
module gate3_response_checker #(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       truth_tbl,
  input  logic             vec_valid,
  input  logic [2:0]       vec,
  input  logic             zn,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       cov,
  output logic             fail_seen,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_got,
  output logic             overrun
);

  typedef enum logic [2:0] {IDLE, ARMED, WAIT, SAMPLE, DONE} state_e;

  state_e           state_q;
  logic [7:0]       tbl_q;
  logic [2:0]       vec_q;
  logic [7:0]       cnt_q;
  logic [ERR_W-1:0] err_q;
  logic [7:0]       cov_q;
  logic             fail_q;
  logic [2:0]       ffv_q;
  logic             ffg_q;
  logic             ovr_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic             mismatch;
  logic [ERR_W-1:0] err_d;
  logic [7:0]       cov_d;

  // Result of the sample in progress; only committed in SAMPLE.
  always_comb begin
    mismatch = (zn != tbl_q[vec_q]);
    err_d    = err_q;
    if (mismatch && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + 1'b1;
    end
    cov_d = cov_q | (8'd1 << vec_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tbl_q   <= 8'd0;
      vec_q   <= 3'd0;
      cnt_q   <= 8'd0;
      err_q   <= '0;
      cov_q   <= 8'd0;
      fail_q  <= 1'b0;
      ffv_q   <= 3'd0;
      ffg_q   <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else if (start) begin
      // Start re-arms from any state; an in-flight or simultaneous vector is dropped.
      state_q <= ARMED;
      tbl_q   <= truth_tbl;
      cnt_q   <= 8'd0;
      err_q   <= '0;
      cov_q   <= 8'd0;
      fail_q  <= 1'b0;
      ffv_q   <= 3'd0;
      ffg_q   <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        ARMED: begin
          if (vec_valid) begin
            vec_q   <= vec;
            cnt_q   <= 8'(SETTLE);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (vec_valid) ovr_q <= 1'b1;
          if (cnt_q == 8'd0) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        SAMPLE: begin
          if (vec_valid) ovr_q <= 1'b1;
          err_q <= err_d;
          cov_q <= cov_d;
          if (mismatch && !fail_q) begin
            fail_q <= 1'b1;
            ffv_q  <= vec_q;
            ffg_q  <= zn;
          end
          if (cov_d == 8'hFF) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= ARMED;
          end
        end
        DONE: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign cov            = cov_q;
  assign fail_seen      = fail_q;
  assign first_fail_vec = ffv_q;
  assign first_fail_got = ffg_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_gate3_response_checker.sv
// Scoreboard bench: drivers push expected snapshots tagged with the cycle they become
// visible; a negedge monitor pops and compares both an 8-bit and a 2-bit error-counter instance.
module tb_gate3_response_checker;

  localparam int SET = 4;

  logic       clk, rst, start, vec_valid, zn;
  logic [7:0] truth_tbl;
  logic [2:0] vec;

  logic       busy, done, pass, fail_seen, first_fail_got, overrun;
  logic [7:0] err_cnt, cov;
  logic [2:0] first_fail_vec;

  logic       busy2, done2, pass2, fail_seen2, first_fail_got2, overrun2;
  logic [1:0] err_cnt2;
  logic [7:0] cov2;
  logic [2:0] first_fail_vec2;

  gate3_response_checker #(.SETTLE(SET), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .truth_tbl(truth_tbl),
    .vec_valid(vec_valid), .vec(vec), .zn(zn),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .cov(cov),
    .fail_seen(fail_seen), .first_fail_vec(first_fail_vec),
    .first_fail_got(first_fail_got), .overrun(overrun)
  );

  gate3_response_checker #(.SETTLE(SET), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .truth_tbl(truth_tbl),
    .vec_valid(vec_valid), .vec(vec), .zn(zn),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2), .cov(cov2),
    .fail_seen(fail_seen2), .first_fail_vec(first_fail_vec2),
    .first_fail_got(first_fail_got2), .overrun(overrun2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    string      name;
    logic       busy, done, pass;
    logic [7:0] err;
    logic [1:0] err2;
    logic [7:0] cov;
    logic       fs;
    logic [2:0] ffv;
    logic       ffg;
    logic       ovr;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  logic [7:0] m_tbl, m_cov;
  int         m_err, m_err2;
  logic       m_busy, m_done, m_fs, m_ffg, m_ovr;
  logic [2:0] m_ffv;

  function automatic exp_t mkRec(input string nm, input int due,
                                 input logic b, input logic d, input logic p,
                                 input logic [7:0] e, input logic [1:0] e2,
                                 input logic [7:0] c, input logic f,
                                 input logic [2:0] fv, input logic fg, input logic o);
    exp_t r;
    r.due = due; r.name = nm; r.busy = b; r.done = d; r.pass = p;
    r.err = e; r.err2 = e2; r.cov = c; r.fs = f; r.ffv = fv; r.ffg = fg; r.ovr = o;
    return r;
  endfunction

  task automatic cmp(input string nm, input string f, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s.%s got=%0h expected=%0h (cycle %0d)", nm, f, act, exp, cyc);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp(e.name, "busy", 8'(busy), 8'(e.busy));
    cmp(e.name, "done", 8'(done), 8'(e.done));
    cmp(e.name, "pass", 8'(pass), 8'(e.pass));
    cmp(e.name, "err_cnt", err_cnt, e.err);
    cmp(e.name, "cov", cov, e.cov);
    cmp(e.name, "fail_seen", 8'(fail_seen), 8'(e.fs));
    cmp(e.name, "first_fail_vec", 8'(first_fail_vec), 8'(e.ffv));
    cmp(e.name, "first_fail_got", 8'(first_fail_got), 8'(e.ffg));
    cmp(e.name, "overrun", 8'(overrun), 8'(e.ovr));
    cmp(e.name, "w2.busy", 8'(busy2), 8'(e.busy));
    cmp(e.name, "w2.done", 8'(done2), 8'(e.done));
    cmp(e.name, "w2.pass", 8'(pass2), 8'(e.pass));
    cmp(e.name, "w2.err_cnt", 8'(err_cnt2), 8'(e.err2));
    cmp(e.name, "w2.cov", cov2, e.cov);
    cmp(e.name, "w2.fail_seen", 8'(fail_seen2), 8'(e.fs));
    cmp(e.name, "w2.first_fail_vec", 8'(first_fail_vec2), 8'(e.ffv));
    cmp(e.name, "w2.first_fail_got", 8'(first_fail_got2), 8'(e.ffg));
    cmp(e.name, "w2.overrun", 8'(overrun2), 8'(e.ovr));
  endtask

  // Monitor: compare every snapshot that falls due this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      if (cur.due < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s stale got=cycle %0d expected=cycle %0d", cur.name, cyc, cur.due);
      end else begin
        checkOutput(cur);
      end
    end
  end

  task automatic pushModel(input string nm, input int due);
    sb.push_back(mkRec(nm, due, m_busy, m_done, m_done && (m_err == 0),
                       8'(m_err), 2'(m_err2), m_cov, m_fs, m_ffv, m_ffg, m_ovr));
  endtask

  task automatic pushHand(input string nm, input logic b, input logic d, input logic p,
                          input logic [7:0] e, input logic [1:0] e2, input logic [7:0] c,
                          input logic f, input logic [2:0] fv, input logic fg, input logic o);
    sb.push_back(mkRec(nm, cyc + 1, b, d, p, e, e2, c, f, fv, fg, o));
    @(negedge clk);
  endtask

  task automatic modelReset();
    m_err = 0; m_err2 = 0; m_cov = 8'h00; m_fs = 1'b0; m_ffv = 3'd0; m_ffg = 1'b0;
    m_ovr = 1'b0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  task automatic modelSample(input logic [2:0] v, input logic z);
    if (!m_busy) return;
    if (z !== m_tbl[v]) begin
      if (m_err < 255) m_err++;
      if (m_err2 < 3) m_err2++;
      if (!m_fs) begin
        m_fs = 1'b1; m_ffv = v; m_ffg = z;
      end
    end
    m_cov[v] = 1'b1;
    if (m_cov == 8'hFF) begin
      m_done = 1'b1; m_busy = 1'b0;
    end
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic doStart(input logic [7:0] tbl, input logic withVec, input logic [2:0] v);
    modelReset();
    m_tbl = tbl; m_busy = 1'b1;
    pushModel("start", cyc + 1);
    start = 1'b1; truth_tbl = tbl; vec_valid = withVec; vec = v;
    @(negedge clk);
    start = 1'b0; vec_valid = 1'b0;
    truth_tbl = ~tbl;
  endtask

  // One vector at the minimum period; zn held until the next vector
  task automatic applyStimulus(input logic [2:0] v, input logic z);
    int k;
    k = cyc;
    vec_valid = 1'b1; vec = v; zn = z;
    modelSample(v, z);
    pushModel("sample", k + SET + 3);
    @(negedge clk);
    vec_valid = 1'b0;
    waitUntil(k + SET + 3);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    logic [2:0] v;
    rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec = 3'd0; zn = 1'b0; truth_tbl = 8'h00;
    m_tbl = 8'h00;
    modelReset();
    @(negedge clk);
    pushHand("reset", 0, 0, 0, 8'd0, 2'd0, 8'h00, 0, 3'd0, 0, 0);
    rst = 1'b0;

    $display("[TB] ideal OR3");
    doStart(8'hFE, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      applyStimulus(v, |v);
    end
    pushHand("or3_final", 0, 1, 1, 8'd0, 2'd0, 8'hFF, 0, 3'd0, 0, 0);

    $display("[TB] zn stuck at 0");
    doStart(8'hFE, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) applyStimulus(3'(i), 1'b0);
    pushHand("stuck0_final", 0, 1, 0, 8'd7, 2'd3, 8'hFF, 1, 3'b001, 0, 0);

    $display("[TB] repeated code 000");
    doStart(8'hFE, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 1'b0);
    for (int i = 1; i < 8; i++) begin
      v = 3'(i);
      applyStimulus(v, |v);
    end
    pushHand("repeat_final", 0, 1, 1, 8'd0, 2'd0, 8'hFF, 0, 3'd0, 0, 0);

    $display("[TB] partial coverage");
    doStart(8'hFE, 1'b0, 3'd0);
    for (int i = 0; i < 7; i++) begin
      v = 3'(i);
      applyStimulus(v, |v);
    end
    pushHand("partial_final", 1, 0, 0, 8'd0, 2'd0, 8'h7F, 0, 3'd0, 0, 0);

    $display("[TB] overrun");
    doStart(8'hFE, 1'b0, 3'd0);
    k = cyc;
    vec_valid = 1'b1; vec = 3'b101; zn = 1'b1;
    modelSample(3'b101, 1'b1);
    m_ovr = 1'b1;
    pushModel("overrun", k + SET + 3);
    @(negedge clk);
    vec_valid = 1'b0;
    @(negedge clk);
    vec_valid = 1'b1; vec = 3'b010;
    @(negedge clk);
    vec_valid = 1'b0;
    waitUntil(k + SET + 3);
    pushHand("overrun_final", 1, 0, 0, 8'd0, 2'd0, 8'h20, 0, 3'd0, 0, 1);

    $display("[TB] mid-run start");
    doStart(8'hFE, 1'b0, 3'd0);
    for (int i = 1; i < 4; i++) applyStimulus(3'(i), 1'b0);
    pushHand("three_fails", 1, 0, 0, 8'd3, 2'd3, 8'h0E, 1, 3'b001, 0, 0);
    k = cyc;
    vec_valid = 1'b1; vec = 3'b100; zn = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0;
    @(negedge clk);
    doStart(8'hFE, 1'b0, 3'd0);
    waitUntil(k + SET + 4);
    pushHand("inflight_dropped", 1, 0, 0, 8'd0, 2'd0, 8'h00, 0, 3'd0, 0, 0);

    $display("[TB] mid-run reset");
    applyStimulus(3'b000, 1'b0);
    vec_valid = 1'b1; vec = 3'b110; zn = 1'b1;
    @(negedge clk);
    vec_valid = 1'b0;
    rst = 1'b1; start = 1'b1;
    modelReset();
    pushHand("reset_over_start", 0, 0, 0, 8'd0, 2'd0, 8'h00, 0, 3'd0, 0, 0);
    rst = 1'b0; start = 1'b0;
    applyStimulus(3'b111, 1'b1);

    $display("[TB] inverse OR3");
    doStart(8'hFE, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      applyStimulus(v, ~(|v));
    end
    pushHand("inverse_final", 0, 1, 0, 8'd8, 2'd3, 8'hFF, 1, 3'b000, 1, 0);

    $display("[TB] done hold and start/vec collision");
    applyStimulus(3'b011, 1'b0);
    doStart(8'hFE, 1'b1, 3'b111);
    k = cyc;
    waitUntil(k + SET + 3);
    pushHand("collision_final", 1, 0, 0, 8'd0, 2'd0, 8'h00, 0, 3'd0, 0, 0);

    repeat (3) @(negedge clk);
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL %s unchecked got=pending expected=checked", cur.name);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
